// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin memory bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RDWAIT} arb_state_t;
   typedef enum logic {RD, WR} bus_op_t;

   function automatic int grant_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request after i_last.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter  int NumReq     = 2,
   localparam int GrantWidth = grant_width(NumReq)
) (
   input  logic [NumReq-1:0]     i_req,
   input  logic [GrantWidth-1:0] i_last,
   output logic                  o_valid,
   output logic [GrantWidth-1:0] o_grant
);

   logic [2*NumReq-1:0] w_req2;

   assign w_req2 = {i_req, i_req};

   // Scan downward so the lowest position after i_last wins.
   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      for (int k = 2*NumReq-1; k >= 0; k--) begin
         if (k > int'(i_last) && k <= int'(i_last) + NumReq && w_req2[k]) begin
            o_valid = 1'b1;
            o_grant = GrantWidth'(k >= NumReq ? k - NumReq : k);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus port between NumReq requesters;
// a grant is held until the owner's transaction completes.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter  int AddrBusWidth = 32,
   parameter  int DataBusWidth = 32,
   parameter  int NumReq       = 2,
   localparam int GrantWidth   = grant_width(NumReq),
   localparam int SelWidth     = DataBusWidth/8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NumReq-1:0][AddrBusWidth-1:0]  addr_m,
   input  logic [NumReq-1:0][DataBusWidth-1:0]  w_data_m,
   input  logic [NumReq-1:0][SelWidth-1:0]      w_sel_m,
   input  logic [NumReq-1:0]                    re_m,
   input  logic [NumReq-1:0]                    we_m,
   output logic [DataBusWidth-1:0]              r_data_m,
   output logic [NumReq-1:0]                    ready_m,
   output logic [NumReq-1:0]                    r_data_valid_m,
   output logic [AddrBusWidth-1:0]              addr_s,
   output logic [DataBusWidth-1:0]              w_data_s,
   output logic [SelWidth-1:0]                  w_sel_s,
   output logic                                 re_s,
   output logic                                 we_s,
   input  logic [DataBusWidth-1:0]              r_data_s,
   input  logic                                 ready_s,
   input  logic                                 r_data_valid_s
);

   arb_state_t            r_state;
   bus_op_t               r_op;
   logic [GrantWidth-1:0] r_owner;
   logic [GrantWidth-1:0] r_last;

   logic [NumReq-1:0]     w_req;
   logic                  w_pick_valid;
   logic [GrantWidth-1:0] w_pick;
   logic                  w_busy;
   logic                  w_rd_go;
   logic                  w_wr_go;

   assign w_req = re_m | we_m;

   rr_picker #(
      .NumReq (NumReq)
   ) u_picker (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_grant (w_pick)
   );

   // Slave side depends only on state and owner inputs, never on ready_s.
   assign w_busy   = (r_state == BUSY);
   assign w_rd_go  = w_busy & (r_op == RD) & re_m[r_owner];
   assign w_wr_go  = w_busy & (r_op == WR) & we_m[r_owner];
   assign re_s     = w_rd_go;
   assign we_s     = w_wr_go;
   assign addr_s   = w_busy ? addr_m[r_owner]   : '0;
   assign w_data_s = w_busy ? w_data_m[r_owner] : '0;
   assign w_sel_s  = w_busy ? w_sel_m[r_owner]  : '0;
   assign r_data_m = r_data_s;

   always_comb begin
      ready_m        = '0;
      r_data_valid_m = '0;
      if ((w_rd_go | w_wr_go) & ready_s)
         ready_m[r_owner] = 1'b1;
      if (w_rd_go & ready_s & r_data_valid_s)
         r_data_valid_m[r_owner] = 1'b1;
      if (r_state == RDWAIT)
         r_data_valid_m[r_owner] = r_data_valid_s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_op    <= RD;
         r_last  <= GrantWidth'(NumReq-1);
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_owner <= w_pick;
                  r_op    <= we_m[w_pick] ? WR : RD;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // Owner withdrew before acceptance: drop without credit.
               if (!(w_rd_go | w_wr_go)) begin
                  r_state <= IDLE;
               end else if (ready_s) begin
                  if (w_wr_go || r_data_valid_s) begin
                     r_last  <= r_owner;
                     r_state <= IDLE;
                  end else begin
                     r_state <= RDWAIT;
                  end
               end
            end
            RDWAIT: begin
               if (r_data_valid_s) begin
                  r_last  <= r_owner;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against
// a transaction-level round-robin model and a memory scoreboard.
module tb_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW/8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [N-1:0][AW-1:0] addr_m;
   logic [N-1:0][DW-1:0] w_data_m;
   logic [N-1:0][SW-1:0] w_sel_m;
   logic [N-1:0]         re_m;
   logic [N-1:0]         we_m;
   logic [DW-1:0]        r_data_m;
   logic [N-1:0]         ready_m;
   logic [N-1:0]         r_data_valid_m;
   logic [AW-1:0]        addr_s;
   logic [DW-1:0]        w_data_s;
   logic [SW-1:0]        w_sel_s;
   logic                 re_s;
   logic                 we_s;
   logic [DW-1:0]        r_data_s;
   logic                 ready_s;
   logic                 r_data_valid_s;

   always #5 clk = ~clk;

   bus_arbiter #(
      .AddrBusWidth (AW),
      .DataBusWidth (DW),
      .NumReq       (N)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .addr_m         (addr_m),
      .w_data_m       (w_data_m),
      .w_sel_m        (w_sel_m),
      .re_m           (re_m),
      .we_m           (we_m),
      .r_data_m       (r_data_m),
      .ready_m        (ready_m),
      .r_data_valid_m (r_data_valid_m),
      .addr_s         (addr_s),
      .w_data_s       (w_data_s),
      .w_sel_s        (w_sel_s),
      .re_s           (re_s),
      .we_s           (we_s),
      .r_data_s       (r_data_s),
      .ready_s        (ready_s),
      .r_data_valid_s (r_data_valid_s)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // requester transaction state
   logic          q_act[N];
   logic          q_wr[N];
   logic          q_re2[N];
   logic          q_acc[N];
   logic [AW-1:0] q_addr[N];
   logic [DW-1:0] q_data[N];
   logic [SW-1:0] q_sel[N];

   // stimulus knobs
   int gen_pct     = 0;
   bit gen_rd_only = 0;
   int abort_pct   = 0;
   int rdy_mode    = 0;
   int lat_fix     = -1;

   // slave memory and reference memory
   logic [DW-1:0] smem[16];
   logic [DW-1:0] rmem[16];
   bit            s_pend = 0;
   int            s_cnt  = 0;
   int            s_lat  = 0;
   logic [3:0]    s_idx  = '0;

   // arbitration model: -1 means bus free
   int m_owner = -1;
   int m_last  = N-1;
   bit m_wr    = 0;
   bit m_acc   = 0;

   function automatic int pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last+k)%N]) return (last+k)%N;
      return -1;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                          input logic [DW-1:0] n,
                                          input logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = o;
      for (int b = 0; b < SW; b++)
         if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         re_m[i]     = q_act[i] & (~q_wr[i] | q_re2[i]);
         we_m[i]     = q_act[i] & q_wr[i];
         addr_m[i]   = q_addr[i];
         w_data_m[i] = q_data[i];
         w_sel_m[i]  = q_sel[i];
      end
   endtask

   task automatic new_txn(input int i, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      q_act[i]  = 1'b1;
      q_wr[i]   = wr;
      q_re2[i]  = 1'b0;
      q_acc[i]  = 1'b0;
      q_addr[i] = a;
      q_data[i] = d;
      q_sel[i]  = s;
   endtask

   task automatic model_check();
      logic [N-1:0] req;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_val;
      bit           act;
      req     = re_m | we_m;
      exp_rdy = '0;
      exp_val = '0;
      check("r_data_bcast", r_data_m, r_data_s);
      if (m_owner < 0) begin
         check("idle_re_s", re_s, 0);
         check("idle_we_s", we_s, 0);
         check("idle_addr_s", addr_s, 0);
         if (req != 0) begin
            m_owner = pick(req, m_last);
            m_wr    = we_m[m_owner];
            m_acc   = 0;
         end
      end else if (!m_acc) begin
         act = m_wr ? we_m[m_owner] : re_m[m_owner];
         check("busy_re_s", re_s, !m_wr && act);
         check("busy_we_s", we_s, m_wr && act);
         if (!act) begin
            m_owner = -1;
         end else begin
            check("busy_addr_s", addr_s, addr_m[m_owner]);
            check("busy_wdata_s", w_data_s, w_data_m[m_owner]);
            check("busy_wsel_s", w_sel_s, w_sel_m[m_owner]);
            if (ready_s) begin
               exp_rdy[m_owner] = 1'b1;
               if (!m_wr && r_data_valid_s) exp_val[m_owner] = 1'b1;
               if (m_wr || r_data_valid_s) begin
                  m_last  = m_owner;
                  m_owner = -1;
               end else begin
                  m_acc = 1;
               end
            end
         end
      end else begin
         check("wait_re_s", re_s, 0);
         check("wait_we_s", we_s, 0);
         if (r_data_valid_s) begin
            exp_val[m_owner] = 1'b1;
            m_last  = m_owner;
            m_owner = -1;
         end
      end
      check("ready_m", ready_m, exp_rdy);
      check("r_data_valid_m", r_data_valid_m, exp_val);

      for (int i = 0; i < N; i++) begin
         if (q_act[i]) begin
            if (q_wr[i] && ready_m[i]) begin
               rmem[q_addr[i][5:2]] = merge(rmem[q_addr[i][5:2]], q_data[i], q_sel[i]);
               q_act[i] = 1'b0;
            end else if (!q_wr[i]) begin
               if (ready_m[i]) q_acc[i] = 1'b1;
               if (r_data_valid_m[i]) begin
                  check("rd_data", r_data_m, rmem[q_addr[i][5:2]]);
                  q_act[i] = 1'b0;
                  q_acc[i] = 1'b0;
               end
            end
         end
      end

      if (we_s && ready_s)
         smem[addr_s[5:2]] = merge(smem[addr_s[5:2]], w_data_s, w_sel_s);
      if (r_data_valid_s) s_pend = 0;
      else if (re_s && ready_s) begin
         s_pend = 1;
         s_cnt  = s_lat - 1;
         s_idx  = addr_s[5:2];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (!q_act[i] && gen_pct > 0 && $urandom_range(99) < gen_pct) begin
            new_txn(i, gen_rd_only ? 1'b0 : 1'($urandom_range(1)),
                    AW'({$urandom_range(15), 2'b00}), $urandom,
                    SW'($urandom_range(15)));
            q_re2[i] = q_wr[i] & 1'($urandom_range(1));
         end else if (q_act[i] && !q_acc[i] && abort_pct > 0 &&
                      $urandom_range(99) < abort_pct) begin
            q_act[i] = 1'b0;
         end
      end
      drive_req();
      #1;
      r_data_s       = $urandom;
      r_data_valid_s = 1'b0;
      ready_s        = (rdy_mode == 1) ? 1'b1 :
                       (rdy_mode == 2) ? 1'b0 : ($urandom_range(2) != 0);
      if (s_pend) begin
         if (s_cnt == 0) begin
            r_data_valid_s = 1'b1;
            r_data_s       = smem[s_idx];
         end else begin
            s_cnt--;
         end
      end else if (re_s && ready_s) begin
         s_lat = (lat_fix >= 0) ? lat_fix : $urandom_range(3);
         if (s_lat == 0) begin
            r_data_valid_s = 1'b1;
            r_data_s       = smem[addr_s[5:2]];
         end
      end
      @(negedge clk);
      model_check();
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         q_act[i] = 1'b0;
         q_acc[i] = 1'b0;
      end
      drive_req();
      m_owner = -1;
      m_last  = N-1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_reqs();
      s_pend         = 0;
      ready_s        = 1'b0;
      r_data_valid_s = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drain();
      int k;
      k        = 0;
      gen_pct  = 0;
      abort_pct = 0;
      rdy_mode = 0;
      lat_fix  = -1;
      while ((q_act[0] || q_act[1] || m_owner >= 0) && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) check("drain_timeout", k, 0);
   endtask

   int order[$];
   int seen;

   initial begin
      for (int i = 0; i < 16; i++) begin
         smem[i] = (i * 32'h11111111) ^ 32'h5a5a0000;
         rmem[i] = smem[i];
      end
      for (int i = 0; i < N; i++) begin
         q_addr[i] = '0;
         q_data[i] = '0;
         q_sel[i]  = '0;
         q_wr[i]   = 1'b0;
         q_re2[i]  = 1'b0;
      end
      r_data_s = '0;
      do_reset();

      ready_s        = 1'b1;
      r_data_valid_s = 1'b1;
      #1;
      check("rst_ready_m", ready_m, 0);
      check("rst_valid_m", r_data_valid_m, 0);
      check("rst_re_s", re_s, 0);
      check("rst_we_s", we_s, 0);
      ready_s        = 1'b0;
      r_data_valid_s = 1'b0;

      // single read, 1-cycle slave latency
      smem[2] = 32'he2e8ae37;
      rmem[2] = 32'he2e8ae37;
      rdy_mode = 1;
      lat_fix  = 1;
      new_txn(0, 1'b0, 32'h08, '0, '0);
      step();
      check("t1_arb_re_s", re_s, 0);
      step();
      check("t1_re_s", re_s, 1);
      check("t1_addr_s", addr_s, 32'h08);
      check("t1_ready_m", ready_m, 2'b01);
      step();
      check("t1_valid_m", r_data_valid_m, 2'b01);
      check("t1_r_data", r_data_m, 32'he2e8ae37);
      step();
      check("t1_idle_re_s", re_s, 0);

      // contention: both readers held, grants alternate from 0
      do_reset();
      gen_pct     = 100;
      gen_rd_only = 1;
      rdy_mode    = 0;
      lat_fix     = -1;
      order.delete();
      for (int c = 0; c < 300 && order.size() < 6; c++) begin
         step();
         check("t2_onehot", $countones(r_data_valid_m) <= 1, 1);
         for (int i = 0; i < N; i++)
            if (r_data_valid_m[i]) order.push_back(i);
      end
      if (order.size() < 6) check("t2_budget", order.size(), 6);
      else for (int k = 0; k < 6; k++) check("t2_order", order[k], k % 2);
      gen_rd_only = 0;
      drain();

      // write with 3 cycles of backpressure
      rdy_mode = 2;
      new_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1001);
      step();
      check("t3_arb_we_s", we_s, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t3_we_s", we_s, 1);
         check("t3_addr_s", addr_s, 32'h10);
         check("t3_wdata_s", w_data_s, 32'hDEADBEEF);
         check("t3_wsel_s", w_sel_s, 4'b1001);
         check("t3_ready_m_lo", ready_m, 0);
      end
      rdy_mode = 1;
      step();
      check("t3_we_s_last", we_s, 1);
      check("t3_ready_m", ready_m, 2'b10);
      step();
      check("t3_we_s_done", we_s, 0);
      check("t3_ready_m_done", ready_m, 0);

      // read raised during another requester's write
      rdy_mode = 2;
      new_txn(0, 1'b1, 32'h20, 32'h12345678, 4'hf);
      step();
      new_txn(1, 1'b0, 32'h24, '0, '0);
      for (int k = 0; k < 2; k++) begin
         step();
         check("t4_re_s_blocked", re_s, 0);
         check("t4_we_s", we_s, 1);
      end
      rdy_mode = 1;
      lat_fix  = 1;
      step();
      check("t4_wr_ready_m", ready_m, 2'b01);
      check("t4_re_s_wr_done", re_s, 0);
      step();
      check("t4_gap_re_s", re_s, 0);
      check("t4_gap_we_s", we_s, 0);
      step();
      check("t4_rd_re_s", re_s, 1);
      check("t4_rd_addr_s", addr_s, 32'h24);
      drain();

      // abort leaves last untouched
      do_reset();
      rdy_mode = 2;
      new_txn(0, 1'b0, 32'h30, '0, '0);
      step();
      step();
      check("t5_re_s", re_s, 1);
      q_act[0] = 1'b0;
      step();
      check("t5_abort_re_s", re_s, 0);
      check("t5_abort_ready", ready_m, 0);
      check("t5_abort_valid", r_data_valid_m, 0);
      new_txn(0, 1'b0, 32'h34, '0, '0);
      new_txn(1, 1'b0, 32'h38, '0, '0);
      rdy_mode = 1;
      lat_fix  = 0;
      step();
      check("t5_arb_re_s", re_s, 0);
      step();
      check("t5_win_addr", addr_s, 32'h34);
      check("t5_win_valid", r_data_valid_m, 2'b01);
      drain();

      // reset while waiting for read data; late data ignored
      rdy_mode = 1;
      lat_fix  = 3;
      new_txn(0, 1'b0, 32'h3c, '0, '0);
      step();
      step();
      check("t6_accept", ready_m, 2'b01);
      step();
      check("t6_wait_valid", r_data_valid_m, 0);
      rst            = 1'b0;
      ready_s        = 1'b1;
      r_data_valid_s = 1'b1;
      #1;
      check("t6_rst_ready", ready_m, 0);
      check("t6_rst_valid", r_data_valid_m, 0);
      check("t6_rst_re_s", re_s, 0);
      r_data_valid_s = 1'b0;
      clear_reqs();
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (r_data_valid_s) begin
            seen++;
            check("t6_stray", r_data_valid_m, 0);
         end
      end
      if (seen == 0) check("t6_stray_budget", seen, 1);

      // random traffic
      do_reset();
      gen_pct   = 40;
      abort_pct = 3;
      rdy_mode  = 0;
      lat_fix   = -1;
      repeat (3000) step();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
